mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Three-way arbiter (program loader, data port, instruction fetch) in front of a
// single-port synchronous memory, with loader bus lock and fetch anti-starvation.
module mem_arbiter #(
  parameter int ADDRESS_BITS = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clock,
  input  logic                    reset,

  input  logic                    ld_req,
  input  logic                    ld_wen,
  input  logic                    ld_lock,
  input  logic [ADDRESS_BITS-1:0] ld_addr,
  input  logic [31:0]             ld_wdata,

  input  logic                    d_req,
  input  logic                    d_wen,
  input  logic [ADDRESS_BITS-1:0] d_addr,
  input  logic [31:0]             d_wdata,

  input  logic                    i_req,
  input  logic [ADDRESS_BITS-1:0] i_addr,

  output logic                    ld_gnt,
  output logic                    d_gnt,
  output logic                    i_gnt,
  output logic                    ld_rvalid,
  output logic                    d_rvalid,
  output logic                    i_rvalid,
  output logic [31:0]             rd_data,

  output logic                    mem_en,
  output logic                    mem_wen,
  output logic [ADDRESS_BITS-1:0] mem_addr,
  output logic [31:0]             mem_wdata,
  input  logic [31:0]             mem_rdata
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  logic [3:0] starve_q, starve_d;
  logic       locked_q, locked_d;
  logic       ld_rvalid_q, ld_rvalid_d;
  logic       d_rvalid_q, d_rvalid_d;
  logic       i_rvalid_q, i_rvalid_d;
  logic       promote;

  // Grants are purely combinational so a request completes in the cycle it is
  // granted. Holding reset low forces every grant off.
  always_comb begin
    ld_gnt  = 1'b0;
    d_gnt   = 1'b0;
    i_gnt   = 1'b0;
    promote = (starve_q == STARVE_MAX);
    if (reset) begin
      if (ld_req) begin
        ld_gnt = 1'b1;
      end else if (!locked_q) begin
        if (i_req && promote) begin
          i_gnt = 1'b1;
        end else if (d_req) begin
          d_gnt = 1'b1;
        end else if (i_req) begin
          i_gnt = 1'b1;
        end
      end
    end
  end

  always_comb begin
    mem_en    = ld_gnt | d_gnt | i_gnt;
    mem_wen   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (ld_gnt) begin
      mem_wen   = ld_wen;
      mem_addr  = ld_addr;
      mem_wdata = ld_wdata;
    end else if (d_gnt) begin
      mem_wen   = d_wen;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (i_gnt) begin
      mem_addr  = i_addr;
    end
  end

  // Lock survives loader idle cycles and drops as soon as ld_lock falls; the
  // counter keeps running while locked so fetch is promoted once it releases.
  always_comb begin
    locked_d = ld_lock & (locked_q | ld_gnt);
    if (i_req && !i_gnt) begin
      starve_d = (starve_q >= STARVE_MAX) ? STARVE_MAX : starve_q + 4'd1;
    end else begin
      starve_d = '0;
    end
    ld_rvalid_d = ld_gnt & ~ld_wen;
    d_rvalid_d  = d_gnt & ~d_wen;
    i_rvalid_d  = i_gnt;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starve_q    <= '0;
      locked_q    <= 1'b0;
      ld_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      i_rvalid_q  <= 1'b0;
    end else begin
      starve_q    <= starve_d;
      locked_q    <= locked_d;
      ld_rvalid_q <= ld_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      i_rvalid_q  <= i_rvalid_d;
    end
  end

  assign ld_rvalid = ld_rvalid_q;
  assign d_rvalid  = d_rvalid_q;
  assign i_rvalid  = i_rvalid_q;
  assign rd_data   = mem_rdata;

`ifndef SYNTHESIS
  a_gnt_onehot : assert property (@(posedge clock) disable iff (!reset)
    $onehot0({ld_gnt, d_gnt, i_gnt}));
  a_rvalid_onehot : assert property (@(posedge clock) disable iff (!reset)
    $onehot0({ld_rvalid, d_rvalid, i_rvalid}));
`endif

endmodule
